// File: rtl/qsys_nios2_ddr3_ram_arb_pkg.sv
// qsys_nios2_ddr3_ram_arb_pkg: shared defaults, FSM states and port indices for the RAM arbiter
package qsys_nios2_ddr3_ram_arb_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int M0 = 0;
    localparam int M1 = 1;
    typedef enum logic {ST_INIT, ST_SERVE} state_e;
endpackage

// File: rtl/qsys_nios2_ddr3_rr_arb2.sv
// qsys_nios2_ddr3_rr_arb2: two-way round-robin grant; history advances only on accepted commands
module qsys_nios2_ddr3_rr_arb2
    import qsys_nios2_ddr3_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);
    // last_q = 1 means m1 was served last, so m0 wins the first tie out of reset
    logic last_q;
    always_comb begin
        grant_o[M0] = req_i[M0] & (~req_i[M1] | last_q);
        grant_o[M1] = req_i[M1] & (~req_i[M0] | ~last_q);
    end
    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b1;
        else if (accept_i && |grant_o) last_q <= grant_o[M1];
    end
endmodule

// File: rtl/qsys_nios2_ddr3_onchip_ram_arbiter.sv
// qsys_nios2_ddr3_onchip_ram_arbiter: shares a single-port on-chip RAM between two Avalon-MM masters
module qsys_nios2_ddr3_onchip_ram_arbiter
    import qsys_nios2_ddr3_ram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                init_done
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                init_done_q;
    logic [1:0]          rdv_q, rdv_d;
    logic [1:0]          req, grant;
    logic                serve;

    assign serve = state_q == ST_SERVE;
    assign req   = serve ? {m1_read | m1_write, m0_read | m0_write} : 2'b00;

    qsys_nios2_ddr3_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req),
        .accept_i (serve),
        .grant_o  (grant)
    );

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        mem_chipselect = |grant;
        mem_write      = grant[M1] ? m1_write : m0_write & grant[M0];
        mem_address    = grant[M1] ? m1_address : m0_address;
        mem_byteenable = grant[M1] ? m1_byteenable : m0_byteenable;
        mem_writedata  = grant[M1] ? m1_writedata : m0_writedata;
        // a read+write together is treated as a write, so it earns no return strobe
        rdv_d[M0]      = grant[M0] & m0_read & ~m0_write;
        rdv_d[M1]      = grant[M1] & m1_read & ~m1_write;
        if (!serve) begin
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_address    = ptr_q;
            mem_byteenable = '1;
            mem_writedata  = '0;
            ptr_d          = ptr_q + 1'b1;
            state_d        = (ptr_q == '1) ? ST_SERVE : ST_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_ON_RESET ? ST_INIT : ST_SERVE;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
            rdv_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            init_done_q <= state_d == ST_SERVE;
            rdv_q       <= rdv_d;
        end
    end

    assign m0_waitrequest   = ~grant[M0];
    assign m1_waitrequest   = ~grant[M1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rdv_q[M0];
    assign m1_readdatavalid = rdv_q[M1];
    assign mem_clken        = 1'b1;
    assign init_done        = init_done_q;
endmodule

// File: tb/tb_qsys_nios2_ddr3_onchip_ram_arbiter.sv
// tb_qsys_nios2_ddr3_onchip_ram_arbiter: directed vector bench with a behavioural single-port RAM
module tb_qsys_nios2_ddr3_onchip_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken, init_done;
    logic [31:0] mem_writedata, mem_readdata;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    qsys_nios2_ddr3_onchip_ram_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .init_done        (init_done)
    );

    // single-port RAM: address latched on the edge, q read combinationally from the array
    logic [31:0] ram [1024];
    logic [9:0]  raddr_q = '0;
    initial for (int i = 0; i < 1024; i++) ram[i] = 32'hA5A5_A5A5;
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            raddr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[raddr_q];

    typedef struct {
        logic        rd0, wr0;
        logic [9:0]  a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic        rd1, wr1;
        logic [9:0]  a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic        ew0, ew1, ev0, ev1;
        logic [31:0] ed0, ed1;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(input logic rd0, wr0, input logic [9:0] a0, input logic [3:0] be0,
                                input logic [31:0] wd0, input logic rd1, wr1, input logic [9:0] a1,
                                input logic [3:0] be1, input logic [31:0] wd1, input logic ew0, ew1,
                                input logic ev0, input logic [31:0] ed0, input logic ev1,
                                input logic [31:0] ed1);
        vec_t v;
        v.rd0 = rd0; v.wr0 = wr0; v.a0 = a0; v.be0 = be0; v.wd0 = wd0;
        v.rd1 = rd1; v.wr1 = wr1; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
        v.ew0 = ew0; v.ew1 = ew1; v.ev0 = ev0; v.ed0 = ed0; v.ev1 = ev1; v.ed1 = ed1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic init_count(output int n, output bit wait_bad);
        n = 0;
        wait_bad = 1'b0;
        while (!init_done && n < 2000) begin
            if (!m0_waitrequest || !m1_waitrequest) wait_bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    initial begin
        int n;
        bit wb;
        vecs[0]  = mk(0,1,10'h3A5,4'hF,32'hDEADBEEF, 0,0,0,0,0, 0,1, 0,0, 0,0);
        vecs[1]  = mk(1,0,10'h3A5,4'hF,0,            0,0,0,0,0, 0,1, 0,0, 0,0);
        vecs[2]  = mk(0,1,10'h3A5,4'h2,32'h0000AB00, 0,0,0,0,0, 0,1, 1,32'hDEADBEEF, 0,0);
        vecs[3]  = mk(1,0,10'h3A5,4'hF,0,            0,0,0,0,0, 0,1, 0,0, 0,0);
        vecs[4]  = mk(0,0,0,0,0,                     0,0,0,0,0, 1,1, 1,32'hDEADABEF, 0,0);
        vecs[5]  = mk(0,0,0,0,0, 0,1,10'h010,4'hF,32'h12345678, 1,0, 0,0, 0,0);
        vecs[6]  = mk(1,0,10'h010,4'hF,0, 1,0,10'h010,4'hF,0,   0,1, 0,0, 0,0);
        vecs[7]  = mk(0,0,0,0,0,          1,0,10'h010,4'hF,0,   1,0, 1,32'h12345678, 0,0);
        vecs[8]  = mk(0,0,0,0,0,          0,0,0,0,0,            1,1, 0,0, 1,32'h12345678);
        for (int i = 9; i <= 16; i++)
            vecs[i] = mk(1,0,10'h3A5,4'hF,0, 1,0,10'h010,4'hF,0, i[0] ? 1'b0 : 1'b1, i[0] ? 1'b1 : 1'b0,
                         (i >= 10) && !i[0], 32'hDEADABEF, (i >= 11) && i[0], 32'h12345678);
        vecs[17] = mk(0,0,0,0,0, 0,0,0,0,0, 1,1, 0,0, 1,32'h12345678);
        vecs[18] = mk(0,0,0,0,0, 0,1,10'h010,4'h0,32'hFFFFFFFF, 1,0, 0,0, 0,0);
        vecs[19] = mk(0,0,0,0,0, 1,0,10'h010,4'hF,0,            1,0, 0,0, 0,0);
        vecs[20] = mk(0,0,0,0,0, 0,0,0,0,0,                     1,1, 0,0, 1,32'h12345678);
        vecs[21] = mk(1,1,10'h020,4'hF,32'h55AA55AA, 0,0,0,0,0, 0,1, 0,0, 0,0);
        vecs[22] = mk(0,0,0,0,0,                     0,0,0,0,0, 1,1, 0,0, 0,0);
        vecs[23] = mk(1,0,10'h020,4'hF,0,            0,0,0,0,0, 0,1, 0,0, 0,0);
        vecs[24] = mk(0,0,0,0,0,                     0,0,0,0,0, 1,1, 1,32'h55AA55AA, 0,0);

        // reset state, then zero-fill with an m0 read of the top word queued throughout
        repeat (3) @(posedge clk);
        #1;
        chk("reset_waitreq0", m0_waitrequest, 1);
        chk("reset_rdv0", m0_readdatavalid, 0);
        chk("reset_init_done", init_done, 0);
        reset = 1'b0;
        m0_address = 10'h3FF; m0_byteenable = 4'hF; m0_read = 1'b1;
        chk("init_first_addr", mem_address, 0);
        chk("init_first_write", {mem_chipselect, mem_write, mem_byteenable}, 6'h3F);
        init_count(n, wb);
        chk("init_cycles", n, 1024);
        chk("init_waitreq", wb, 0);
        @(negedge clk);
        chk("post_init_grant0", m0_waitrequest, 0);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        chk("zero_rdv0", m0_readdatavalid, 1);
        chk("zero_data", m0_readdata, 0);

        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            m0_read = vecs[i].rd0; m0_write = vecs[i].wr0; m0_address = vecs[i].a0;
            m0_byteenable = vecs[i].be0; m0_writedata = vecs[i].wd0;
            m1_read = vecs[i].rd1; m1_write = vecs[i].wr1; m1_address = vecs[i].a1;
            m1_byteenable = vecs[i].be1; m1_writedata = vecs[i].wd1;
            @(negedge clk);
            chk($sformatf("v%0d_wait0", i), m0_waitrequest, vecs[i].ew0);
            chk($sformatf("v%0d_wait1", i), m1_waitrequest, vecs[i].ew1);
            chk($sformatf("v%0d_rdv0", i), m0_readdatavalid, vecs[i].ev0);
            chk($sformatf("v%0d_rdv1", i), m1_readdatavalid, vecs[i].ev1);
            if (vecs[i].ev0) chk($sformatf("v%0d_data0", i), m0_readdata, vecs[i].ed0);
            if (vecs[i].ev1) chk($sformatf("v%0d_data1", i), m1_readdata, vecs[i].ed1);
        end

        // reset on the edge that would register an in-flight read: no strobe, INIT restarts
        @(posedge clk);
        #1;
        reset = 1'b1;
        m0_read = 1'b1; m0_write = 1'b0; m0_address = 10'h3A5;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_inflight_rdv0", m0_readdatavalid, 0);
        chk("rst_restart_addr", mem_address, 0);
        chk("rst_waitreq0", m0_waitrequest, 1);
        n = 0;
        while (mem_address != 10'h200 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_init_ptr", mem_address, 10'h200);
        chk("mid_init_done", init_done, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("reinit_addr", mem_address, 0);
        chk("reinit_done_low", init_done, 0);
        init_count(n, wb);
        chk("reinit_cycles", n, 1024);
        chk("reinit_waitreq", wb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
